// File: rtl/lsu_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bridge
//  Purpose  : Bridges the MEM-stage load/store request of a RISC-V style
//             pipeline onto a simple valid/ready word-oriented memory bus.
//             Performs alignment and encoding checks, byte-lane strobe and
//             data replication for stores, and byte/halfword extraction with
//             sign/zero extension for loads. Freezes the pipeline while a
//             transaction is outstanding and bounds each memory wait to 16
//             cycles.
//  Ports    :
//     clk, rst            clock, asynchronous active-high reset
//     MemReq, DMWr        access present, 1 = store / 0 = load
//     DMCtrl              funct3 size/extension code
//     Address, DataWr     byte address and store data (rs2)
//     DataRd              registered, aligned and extended load result
//     Stall               pipeline freeze
//     Done                one-cycle completion pulse
//     Misaligned, BusErr  one-cycle fault pulses (alignment/encoding, timeout)
//     mem_*               memory request bus (registered) and response inputs
//  Revision : 1.0  initial release
// ============================================================================
module lsu_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReq,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   output logic [31:0] DataRd,
   output logic        Stall,
   output logic        Done,
   output logic        Misaligned,
   output logic        BusErr,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;
   localparam logic [3:0] c_WAIT_MAX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_ctrl;
   logic [1:0]  r_addr_lo;
   logic [3:0]  r_cnt;
   logic        r_bus_err;    // ERR cause: 1 = timeout, 0 = alignment/encoding
   logic [31:0] r_data_rd;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_wstrb;
   logic [31:0] r_mem_wdata;

   logic        w_legal;
   logic [3:0]  w_strb;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   // Legality of the live request; BU/HU have no store counterpart.
   always_comb begin
      w_legal = 1'b0;
      case (DMCtrl)
         c_F3_B:  w_legal = 1'b1;
         c_F3_H:  w_legal = ~Address[0];
         c_F3_W:  w_legal = (Address[1:0] == 2'b00);
         c_F3_BU: w_legal = ~DMWr;
         c_F3_HU: w_legal = ~DMWr & ~Address[0];
         default: w_legal = 1'b0;
      endcase
   end

   // Lane strobes and replicated store data from the live request.
   always_comb begin
      w_strb  = 4'b0000;
      w_wdata = 32'd0;
      if (DMWr) begin
         case (DMCtrl)
            c_F3_B: begin
               w_strb  = 4'b0001 << Address[1:0];
               w_wdata = {4{DataWr[7:0]}};
            end
            c_F3_H: begin
               w_strb  = Address[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{DataWr[15:0]}};
            end
            c_F3_W: begin
               w_strb  = 4'b1111;
               w_wdata = DataWr;
            end
            default: begin
               w_strb  = 4'b0000;
               w_wdata = 32'd0;
            end
         endcase
      end
   end

   // Load extraction uses the latched size code and address offset.
   always_comb begin
      w_byte = mem_rdata[7:0];
      case (r_addr_lo)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_ctrl)
         c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
         c_F3_BU: w_load_data = {24'd0, w_byte};
         c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
         c_F3_HU: w_load_data = {16'd0, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   // Next-state and status outputs. Stall is combinational so the pipeline
   // freezes in the same cycle the request is presented.
   always_comb begin
      w_next     = r_state;
      Stall      = 1'b0;
      Done       = 1'b0;
      Misaligned = 1'b0;
      BusErr     = 1'b0;
      mem_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MemReq) begin
               Stall  = 1'b1;
               w_next = w_legal ? ST_REQ : ST_ERR;
            end
         end
         ST_REQ: begin
            mem_valid = 1'b1;
            Stall     = 1'b1;
            if (mem_ready) begin
               w_next = ST_RESP;
            end else if (r_cnt == c_WAIT_MAX) begin
               w_next = ST_ERR;
            end
         end
         ST_RESP: begin
            Done   = 1'b1;
            w_next = ST_IDLE;
         end
         ST_ERR: begin
            Misaligned = ~r_bus_err;
            BusErr     = r_bus_err;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ctrl      <= 3'd0;
         r_addr_lo   <= 2'd0;
         r_cnt       <= 4'd0;
         r_bus_err   <= 1'b0;
         r_data_rd   <= 32'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wstrb <= 4'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (MemReq) begin
                  r_bus_err <= 1'b0;
                  if (w_legal) begin
                     r_ctrl      <= DMCtrl;
                     r_addr_lo   <= Address[1:0];
                     r_cnt       <= 4'd0;
                     r_mem_we    <= DMWr;
                     r_mem_addr  <= {Address[31:2], 2'b00};
                     r_mem_wstrb <= w_strb;
                     r_mem_wdata <= w_wdata;
                  end
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  if (!r_mem_we) begin
                     r_data_rd <= w_load_data;
                  end
               end else if (r_cnt == c_WAIT_MAX) begin
                  r_bus_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign DataRd    = r_data_rd;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wstrb = r_mem_wstrb;
   assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
